// File: rtl/histogram_accumulator_if.sv
// Bus bundle for histogram_accumulator: control handshake, m1 read port, m2 read/write ports.
interface histogram_accumulator_if #(
    parameter int WORD_W = 128,
    parameter int ADDR_W = 16
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] num_words;
    logic [ADDR_W-1:0] word_base;
    logic [ADDR_W-1:0] bin_base;
    logic [WORD_W-1:0] m1ReadBus;
    logic [ADDR_W-1:0] m1ReadAddr;
    logic [WORD_W-1:0] m2ReadBus;
    logic [ADDR_W-1:0] m2ReadAddr;
    logic [ADDR_W-1:0] m2WriteAddr;
    logic [WORD_W-1:0] m2WriteBus;
    logic              m2WE;
    logic              busy;
    logic              done;

    modport slave (
        input  start, abort, num_words, word_base, bin_base, m1ReadBus, m2ReadBus,
        output m1ReadAddr, m2ReadAddr, m2WriteAddr, m2WriteBus, m2WE, busy, done
    );

    modport master (
        output start, abort, num_words, word_base, bin_base, m1ReadBus, m2ReadBus,
        input  m1ReadAddr, m2ReadAddr, m2WriteAddr, m2WriteBus, m2WE, busy, done
    );
endinterface

// File: rtl/histogram_accumulator.sv
// Streams packed pixel words from m1 and keeps a tagged, saturating bin count per pixel
// value in m2 through a SEL/FI/FS/ACC read-modify-write pipeline with forwarding.
//
// state | meaning
// IDLE  | waiting for start
// PRIME | first m1 word address issued
// RUN   | one pixel selected per cycle
// DRAIN | pipeline emptying (3 cycles)
// DONE  | run complete, done held until next start
module histogram_accumulator #(
    parameter int PIXEL_W = 8,
    parameter int WORD_W  = 128,
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 20,
    parameter int TAG_W   = 16,
    parameter logic [TAG_W-1:0] TAG_VAL = 16'hAAAA
) (
    input logic clock,
    input logic rst_n,
    histogram_accumulator_if.slave bus
);
    localparam int PPW    = WORD_W / PIXEL_W;
    localparam int LANE_W = $clog2(PPW);
    localparam logic [LANE_W-1:0]  LANE_LAST = LANE_W'(PPW - 1);
    localparam logic [LANE_W-1:0]  LANE_ADV  = LANE_W'(PPW - 2);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [ADDR_W-1:0]  word_q, word_d;
    logic [1:0]         drain_q, drain_d;
    logic [ADDR_W-1:0]  m1_addr_q, m1_addr_d;
    logic [ADDR_W-1:0]  num_words_q, num_words_d;
    logic [ADDR_W-1:0]  bin_base_q, bin_base_d;
    logic [WORD_W-1:0]  word_data_q;

    logic               fi_valid_q, fs_valid_q, acc_valid_q, wb_valid_q;
    logic [ADDR_W-1:0]  fi_addr_q, fs_addr_q, acc_addr_q, wb_addr_q;
    logic [COUNT_W-1:0] acc_cnt_q, wb_cnt_q;

    logic               sel_valid;
    logic [PIXEL_W-1:0] sel_pix;
    logic [ADDR_W-1:0]  sel_addr;
    logic               m2_tag_ok;
    logic [COUNT_W-1:0] merged;
    logic [COUNT_W-1:0] acc_cnt_d;
    logic               unused_bits;

    assign sel_valid = (state_q == S_RUN);
    assign sel_pix   = (lane_q == '0) ? bus.m1ReadBus[PIXEL_W-1:0]
                                      : word_data_q[lane_q*PIXEL_W +: PIXEL_W];
    assign sel_addr  = bin_base_q + ADDR_W'(sel_pix);
    assign m2_tag_ok = (bus.m2ReadBus[COUNT_W +: TAG_W] == TAG_VAL);
    assign unused_bits = ^bus.m2ReadBus[WORD_W-1:COUNT_W+TAG_W];

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        word_d      = word_q;
        drain_d     = drain_q;
        m1_addr_d   = m1_addr_q;
        num_words_d = num_words_q;
        bin_base_d  = bin_base_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    if (bus.num_words == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_PRIME;
                        num_words_d = bus.num_words;
                        bin_base_d  = bus.bin_base;
                        m1_addr_d   = bus.word_base;
                        lane_d      = '0;
                        word_d      = '0;
                    end
                end
            end
            S_PRIME: state_d = S_RUN;
            S_RUN: begin
                lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
                if (lane_q == LANE_LAST) word_d = word_q + 1'b1;
                // Address moves one lane early so the next word lands exactly at lane 0.
                if (lane_q == LANE_ADV) m1_addr_d = m1_addr_q + 1'b1;
                if (lane_q == LANE_LAST && word_q == num_words_q - 1'b1) begin
                    state_d = S_DRAIN;
                    drain_d = 2'd2;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_DONE;
                else drain_d = drain_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) state_d = S_IDLE;
    end

    // Youngest in-flight value wins: ACC (not yet written), then WB (write racing the read).
    always_comb begin
        merged = '0;
        if (acc_valid_q && acc_addr_q == fs_addr_q) merged = acc_cnt_q;
        else if (wb_valid_q && wb_addr_q == fs_addr_q) merged = wb_cnt_q;
        else if (m2_tag_ok) merged = bus.m2ReadBus[COUNT_W-1:0];
        acc_cnt_d = (merged == COUNT_MAX) ? merged : merged + 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            word_q      <= '0;
            drain_q     <= '0;
            m1_addr_q   <= '0;
            num_words_q <= '0;
            bin_base_q  <= '0;
            word_data_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            drain_q     <= drain_d;
            m1_addr_q   <= m1_addr_d;
            num_words_q <= num_words_d;
            bin_base_q  <= bin_base_d;
            if (sel_valid && lane_q == '0) word_data_q <= bus.m1ReadBus;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            fi_valid_q  <= 1'b0;
            fs_valid_q  <= 1'b0;
            acc_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            fi_addr_q   <= '0;
            fs_addr_q   <= '0;
            acc_addr_q  <= '0;
            wb_addr_q   <= '0;
            acc_cnt_q   <= '0;
            wb_cnt_q    <= '0;
        end else begin
            fi_valid_q  <= sel_valid & ~bus.abort;
            fs_valid_q  <= fi_valid_q & ~bus.abort;
            acc_valid_q <= fs_valid_q & ~bus.abort;
            wb_valid_q  <= acc_valid_q & ~bus.abort;
            if (sel_valid) fi_addr_q <= sel_addr;
            if (fi_valid_q) fs_addr_q <= fi_addr_q;
            if (fs_valid_q) begin
                acc_addr_q <= fs_addr_q;
                acc_cnt_q  <= acc_cnt_d;
            end
            if (acc_valid_q) begin
                wb_addr_q <= acc_addr_q;
                wb_cnt_q  <= acc_cnt_q;
            end
        end
    end

    assign bus.m1ReadAddr  = m1_addr_q;
    assign bus.m2ReadAddr  = fi_addr_q;
    assign bus.m2WriteAddr = acc_addr_q;
    assign bus.m2WE        = acc_valid_q;
    assign bus.m2WriteBus  = acc_valid_q ? WORD_W'({TAG_VAL, acc_cnt_q}) : '0;
    assign bus.busy        = (state_q == S_PRIME) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done        = (state_q == S_DONE);
endmodule
